// File: rtl/adxl362_reg_arbiter_if.sv
// Register-file arbiter bus: two requester ports (SPI slave, sample engine)
// plus the shared register-file port. The slave modport is the arbiter view.
interface adxl362_reg_arbiter_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
);
    logic                  spi_req;
    logic                  spi_we;
    logic [ADDR_WIDTH-1:0] spi_addr;
    logic [DATA_WIDTH-1:0] spi_wdata;
    logic                  spi_lock;
    logic                  spi_ack;
    logic [DATA_WIDTH-1:0] spi_rdata;

    logic                  smp_req;
    logic                  smp_we;
    logic [ADDR_WIDTH-1:0] smp_addr;
    logic [DATA_WIDTH-1:0] smp_wdata;
    logic                  smp_ack;
    logic [DATA_WIDTH-1:0] smp_rdata;

    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_write;
    logic                  write;
    logic                  read;
    logic [DATA_WIDTH-1:0] data_read;

    logic [7:0]            conflict_cnt;

    modport slave (
        input  spi_req, spi_we, spi_addr, spi_wdata, spi_lock,
        output spi_ack, spi_rdata,
        input  smp_req, smp_we, smp_addr, smp_wdata,
        output smp_ack, smp_rdata,
        output address, data_write, write, read,
        input  data_read,
        output conflict_cnt
    );

    modport master (
        output spi_req, spi_we, spi_addr, spi_wdata, spi_lock,
        input  spi_ack, spi_rdata,
        output smp_req, smp_we, smp_addr, smp_wdata,
        input  smp_ack, smp_rdata,
        input  address, data_write, write, read,
        output data_read,
        input  conflict_cnt
    );
endinterface

// File: rtl/adxl362_reg_arbiter.sv
// Round-robin arbiter between the SPI slave and the sample engine for the
// single ADXL362 register-file port. Each access is IDLE -> ISSUE -> COMPLETE.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | pick a winner and latch its access onto the register bus
// ISSUE    | one-cycle read or write strobe on the register bus
// COMPLETE | winner's ack pulse (and read data) is presented
module adxl362_reg_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
) (
    input logic clk,
    input logic rst,
    adxl362_reg_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, COMPLETE} state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  last_spi;
    logic                  grant_spi;
    logic                  cur_spi;
    logic                  contested;
    logic                  any_req;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and grant decision; lock keeps an SPI burst ahead of samples.
    always_comb begin
        state_nxt = state;
        contested = bus.spi_req & bus.smp_req;
        any_req   = bus.spi_req | bus.smp_req;
        grant_spi = 1'b0;
        if (contested) grant_spi = bus.spi_lock | ~last_spi;
        else           grant_spi = bus.spi_req;
        sel_we    = grant_spi ? bus.spi_we    : bus.smp_we;
        sel_addr  = grant_spi ? bus.spi_addr  : bus.smp_addr;
        sel_wdata = grant_spi ? bus.spi_wdata : bus.smp_wdata;
        unique case (state)
            IDLE:     if (any_req) state_nxt = ISSUE;
            ISSUE:    state_nxt = COMPLETE;
            COMPLETE: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Registered bus outputs; data_read is taken at the end of the strobe
    // cycle so read data appears together with the ack pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_spi         <= 1'b0;
            cur_spi          <= 1'b0;
            bus.address      <= '0;
            bus.data_write   <= '0;
            bus.write        <= 1'b0;
            bus.read         <= 1'b0;
            bus.spi_ack      <= 1'b0;
            bus.smp_ack      <= 1'b0;
            bus.spi_rdata    <= '0;
            bus.smp_rdata    <= '0;
            bus.conflict_cnt <= '0;
        end else begin
            bus.write   <= 1'b0;
            bus.read    <= 1'b0;
            bus.spi_ack <= 1'b0;
            bus.smp_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (contested && bus.conflict_cnt != 8'hFF)
                        bus.conflict_cnt <= bus.conflict_cnt + 8'd1;
                    if (any_req) begin
                        cur_spi        <= grant_spi;
                        last_spi       <= grant_spi;
                        bus.address    <= sel_addr;
                        bus.data_write <= sel_wdata;
                        bus.write      <= sel_we;
                        bus.read       <= ~sel_we;
                    end
                end
                ISSUE: begin
                    if (cur_spi) begin
                        bus.spi_ack <= 1'b1;
                        if (bus.read) bus.spi_rdata <= bus.data_read;
                    end else begin
                        bus.smp_ack <= 1'b1;
                        if (bus.read) bus.smp_rdata <= bus.data_read;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
